// File: rtl/line_in_sampler.sv
`timescale 1ns/1ps
// Codec line-in capture: mixes the L/R words to mono, rounds 24-bit to 16-bit,
// queues the samples in a small FIFO behind valid/ready and drives a peak meter.
module line_in_sampler #(
    parameter int FIFO_AW     = 3,
    parameter int PEAK_WINDOW = 4800
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_frame,
    input  logic [23:0]        line_in_l,
    input  logic [23:0]        line_in_r,
    input  logic [1:0]         mono_sel,
    output logic [15:0]        sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic [3:0]         peak_level
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int WCW   = $clog2(PEAK_WINDOW + 1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = (FIFO_AW)'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [WCW-1:0]     WC_ONE   = (WCW)'(1);
    localparam logic [WCW-1:0]     WC_LAST  = (WCW)'(PEAK_WINDOW - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, CONVERT, PUSH} state_t;

    state_t              r_state;
    logic                r_nf_q;
    logic signed [23:0]  r_l;
    logic signed [23:0]  r_r;
    logic [1:0]          r_sel;
    logic signed [24:0]  r_mix;
    logic [15:0]         r_conv;
    logic [15:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_count;
    logic [15:0]         r_head;
    logic                r_overflow;
    logic [14:0]         r_pk;
    logic [WCW-1:0]      r_wcnt;
    logic [3:0]          r_peak;

    logic                w_rise;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;
    logic [FIFO_AW-1:0]  w_rd_next;
    logic signed [24:0]  w_sum;
    logic signed [24:0]  w_mix;
    logic signed [24:0]  w_rnd;
    logic [15:0]         w_conv;
    logic [14:0]         w_neg;
    logic [14:0]         w_abs;
    logic [14:0]         w_pk_next;
    logic [3:0]          w_therm;

    assign w_rise     = new_frame && !r_nf_q;
    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && sample_ready;
    assign w_push_req = (r_state == PUSH);
    // A full FIFO still takes the new word when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_rd_next  = r_rd_ptr + PTR_ONE;

    always_comb begin
        w_sum = {r_l[23], r_l} + {r_r[23], r_r};
        case (r_sel)
            2'b00:   w_mix = {r_l[23], r_l};
            2'b01:   w_mix = {r_r[23], r_r};
            default: w_mix = w_sum >>> 1;
        endcase
    end

    // Round half-up into the kept 16 bits; only the positive side can overflow.
    assign w_rnd  = r_mix + 25'sd128;
    assign w_conv = (w_rnd > 25'sh7FFFFF) ? 16'h7FFF : w_rnd[23:8];

    assign w_neg     = ~r_conv[14:0] + 15'd1;
    assign w_abs     = r_conv[15] ? ((r_conv == 16'h8000) ? 15'h7FFF : w_neg) : r_conv[14:0];
    assign w_pk_next = (w_abs > r_pk) ? w_abs : r_pk;
    assign w_therm   = {w_pk_next >= 15'd16384, w_pk_next >= 15'd8192,
                        w_pk_next >= 15'd4096,  w_pk_next >= 15'd2048};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_nf_q  <= 1'b0;
            r_l     <= '0;
            r_r     <= '0;
            r_sel   <= '0;
            r_mix   <= '0;
            r_conv  <= '0;
        end else begin
            r_nf_q <= new_frame;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_l     <= line_in_l;
                        r_r     <= line_in_r;
                        r_sel   <= mono_sel;
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_mix   <= w_mix;
                    r_state <= CONVERT;
                end
                CONVERT: begin
                    r_conv  <= w_conv;
                    r_state <= PUSH;
                end
                PUSH:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_conv;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) r_overflow <= 1'b1;
            // Head register tracks the next entry, or the incoming word when it becomes head.
            if (w_pop && (r_count > CNT_ONE)) begin
                r_head <= r_mem[w_rd_next];
            end else if (w_push && (w_empty || ((r_count == CNT_ONE) && w_pop))) begin
                r_head <= r_conv;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pk   <= '0;
            r_wcnt <= '0;
            r_peak <= '0;
        end else if (w_push) begin
            if (r_wcnt == WC_LAST) begin
                r_peak <= w_therm;
                r_pk   <= '0;
                r_wcnt <= '0;
            end else begin
                r_pk   <= w_pk_next;
                r_wcnt <= r_wcnt + WC_ONE;
            end
        end
    end

    assign sample_out   = r_head;
    assign sample_valid = !w_empty;
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;
    assign peak_level   = r_peak;

endmodule

// File: tb/tb_line_in_sampler.sv
`timescale 1ns/1ps
// Bench for line_in_sampler: a frame-level reference model predicts accepted
// samples, occupancy, overflow and peak meter; a monitor compares every cycle.
module tb_line_in_sampler;
    localparam int FIFO_AW     = 3;
    localparam int PEAK_WINDOW = 4;
    localparam int DEPTH       = 1 << FIFO_AW;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               new_frame = 1'b0;
    logic [23:0]        line_in_l = '0;
    logic [23:0]        line_in_r = '0;
    logic [1:0]         mono_sel = '0;
    logic [15:0]        sample_out;
    logic               sample_valid;
    logic               sample_ready = 1'b0;
    logic [FIFO_AW:0]   fifo_count;
    logic               overflow;
    logic [3:0]         peak_level;

    always #5 clk = ~clk;

    line_in_sampler #(.FIFO_AW(FIFO_AW), .PEAK_WINDOW(PEAK_WINDOW)) dut (
        .clk(clk), .reset(reset), .new_frame(new_frame),
        .line_in_l(line_in_l), .line_in_r(line_in_r), .mono_sel(mono_sel),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .fifo_count(fifo_count), .overflow(overflow), .peak_level(peak_level)
    );

    int   checks = 0;
    int   failures = 0;
    int   exp_q[$];
    int   m_cnt = 0;
    int   m_busy = 0;
    int   m_val = 0;
    int   m_pk = 0;
    int   m_wcnt = 0;
    logic m_nf_prev = 1'b0;
    logic m_ovf = 1'b0;
    logic [3:0] m_peak = '0;
    bit   rand_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mono mix, round to nearest on the top 16 bits, clip only on the positive side.
    function automatic int ref_sample(input logic [23:0] l, input logic [23:0] r, input logic [1:0] sel);
        int li, ri, mix, rr;
        li = $signed(l);
        ri = $signed(r);
        if (sel == 2'b00)      mix = li;
        else if (sel == 2'b01) mix = ri;
        else                   mix = (li + ri) >>> 1;
        rr = mix + 128;
        if (rr > 8388607) return 32767;
        return rr >>> 8;
    endfunction

    function automatic logic [3:0] ref_therm(input int pk);
        return {pk >= 16384, pk >= 8192, pk >= 4096, pk >= 2048};
    endfunction

    // Reference model: a frame is accepted when the sampler is idle; its word reaches
    // the queue three cycles later, or is lost if the queue is full and nothing leaves.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_cnt = 0; m_busy = 0; m_nf_prev = 1'b0; m_ovf = 1'b0;
                m_peak = '0; m_pk = 0; m_wcnt = 0;
                exp_q.delete();
            end else begin
                bit pop_now, push_now;
                int a;
                pop_now  = (m_cnt > 0) && sample_ready;
                push_now = 1'b0;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) push_now = 1'b1;
                end else if (new_frame && !m_nf_prev) begin
                    m_val  = ref_sample(line_in_l, line_in_r, mono_sel);
                    m_busy = 3;
                end
                m_nf_prev = new_frame;
                if (pop_now) m_cnt--;
                if (push_now) begin
                    if (m_cnt < DEPTH) begin
                        exp_q.push_back(m_val);
                        m_cnt++;
                        a = (m_val < 0) ? -m_val : m_val;
                        if (a > 32767) a = 32767;
                        if (a > m_pk) m_pk = a;
                        m_wcnt++;
                        if (m_wcnt == PEAK_WINDOW) begin
                            m_peak = ref_therm(m_pk);
                            m_pk = 0;
                            m_wcnt = 0;
                        end
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("fifo_count", 32'(fifo_count), m_cnt);
                check("sample_valid", 32'(sample_valid), 32'(m_cnt > 0));
                check("overflow", 32'(overflow), 32'(m_ovf));
                check("peak_level", 32'(peak_level), 32'(m_peak));
                if (sample_valid && sample_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pop_unexpected: got 0x%0h expected no sample at %0t", sample_out, $time);
                    end else begin
                        check("sample_data", 32'($signed(sample_out)), exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) sample_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        new_frame = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r, input logic [1:0] sel,
                         input int hi, input int lo);
        line_in_l = l;
        line_in_r = r;
        mono_sel  = sel;
        new_frame = 1'b1;
        tick(hi);
        new_frame = 1'b0;
        tick(lo);
    endtask

    // Starting from an empty FIFO with ready low: checks latency and the head value.
    task automatic one_sample(input string name, input logic [23:0] l, input logic [23:0] r,
                              input logic [1:0] sel, input logic [15:0] exp);
        frame(l, r, sel, 1, 2);
        check({name, "_not_yet"}, 32'(sample_valid), 32'd0);
        tick(1);
        check({name, "_valid"}, 32'(sample_valid), 32'd1);
        check({name, "_value"}, 32'(sample_out), 32'(exp));
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        tick(1);
    endtask

    function automatic logic [23:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            2:       return 24'(int'($urandom_range(0, 511)) - 256);
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        tick(1);
        check("rst_sample_out", 32'(sample_out), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_peak", 32'(peak_level), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(2);

        one_sample("left",      24'h123456, 24'h000000, 2'b00, 16'h1234);
        one_sample("right",     24'h000000, 24'hABCDEF, 2'b01, 16'hABCE);
        one_sample("avg_sat",   24'h7FFFFF, 24'h7FFFFF, 2'b10, 16'h7FFF);
        one_sample("avg_min",   24'h800000, 24'h800000, 2'b11, 16'h8000);
        one_sample("round_up",  24'h0000FF, 24'h000000, 2'b00, 16'h0001);
        one_sample("round_neg", 24'hFFFF7F, 24'h000000, 2'b00, 16'hFFFF);

        do_reset();
        sample_ready = 1'b0;
        for (int i = 0; i < 9; i++) frame(24'h001000 * (i + 1), 24'h0, 2'b00, 1, 4);
        tick(2);
        check("fill_count", 32'(fifo_count), 32'd8);
        check("fill_overflow", 32'(overflow), 32'd1);
        sample_ready = 1'b1;
        tick(12);
        check("drain_valid", 32'(sample_valid), 32'd0);
        check("drain_queue_left", exp_q.size(), 32'd0);

        do_reset();
        sample_ready = 1'b0;
        for (int i = 0; i < 8; i++) frame(24'h010000 * (i + 1), 24'h0, 2'b00, 1, 4);
        tick(2);
        check("full_count", 32'(fifo_count), 32'd8);
        line_in_l = 24'h345678;
        new_frame = 1'b1;
        tick(1);
        new_frame = 1'b0;
        tick(2);
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        tick(2);
        check("full_pop_count", 32'(fifo_count), 32'd8);
        check("full_pop_overflow", 32'(overflow), 32'd0);
        sample_ready = 1'b1;
        tick(12);

        do_reset();
        sample_ready = 1'b1;
        frame(24'h090000, 24'h0, 2'b00, 1, 4);
        frame(24'hC00000, 24'h0, 2'b00, 1, 4);
        frame(24'h000000, 24'h0, 2'b00, 1, 4);
        frame(24'h000000, 24'h0, 2'b00, 1, 4);
        check("peak_window1", 32'(peak_level), 32'hF);
        for (int i = 0; i < 4; i++) frame(24'h090000, 24'h0, 2'b00, 1, 4);
        check("peak_window2", 32'(peak_level), 32'h1);

        sample_ready = 1'b0;
        line_in_l = 24'h222222;
        new_frame = 1'b1;
        tick(1);
        new_frame = 1'b0;
        tick(1);
        reset = 1'b1;
        #1;
        check("midrst_sample_out", 32'(sample_out), 32'd0);
        check("midrst_valid", 32'(sample_valid), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_peak", 32'(peak_level), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(6);
        check("midrst_no_push", 32'(sample_valid), 32'd0);

        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            frame(rand_word(), rand_word(), 2'($urandom_range(0, 3)),
                  $urandom_range(1, 3), $urandom_range(0, 4));
        end
        rand_mode = 1'b0;
        sample_ready = 1'b1;
        tick(20);
        check("final_count", 32'(fifo_count), 32'd0);
        check("final_queue_left", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
